// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   Final pipeline stage. Consumes the MEM/WB bundle, owns the 32x64 integer
//   register file (two asynchronous read ports for decode, one write port),
//   buffers pending stores in a FIFO drained to the memory commit port, and
//   sequences ecall (drain stores, raise the request, write the result to x10).
//
// Parameters
//   STQ_DEPTH       store-queue entries (power of 2, >= 2)
//   STACK_PTR_INIT  reset value of x2 (sp)
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   memwb_*, dataselect      MEM/WB bundle from the memory stage
//   rd_addr1/2, rd_data1/2   decode register read ports
//   wb_stall                 back-pressure to the memory stage
//   st_valid/ready/addr/value/size   store commit port (queue head)
//   ecall_req/args/done/ret  ecall handshake; args = {x17,...,x10}
//   retire_count             instructions accepted since reset
//
// Configuration macro
//   WB_BYPASS_EN  when defined, an accepted register write (or the x10 write on
//                 ecall_done) is forwarded combinationally to matching read
//                 ports in the same cycle. When undefined, reads return stored
//                 register contents only.
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int          STQ_DEPTH      = 4,
    parameter logic [63:0] STACK_PTR_INIT = 64'h0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memwb_ready,
    input  logic         memwb_wbactive,
    input  logic [5:0]   memwb_rd,
    input  logic [63:0]  memwb_aluresult,
    input  logic [63:0]  memwb_loadeddata,
    input  logic         dataselect,
    input  logic         memwb_ecall,
    input  logic         memwb_pend_write,
    input  logic [3:0]   memwb_size,
    input  logic [63:0]  memwb_value,
    input  logic [63:0]  memwb_addr,
    input  logic [4:0]   rd_addr1,
    input  logic [4:0]   rd_addr2,
    output logic [63:0]  rd_data1,
    output logic [63:0]  rd_data2,
    output logic         wb_stall,
    output logic         st_valid,
    input  logic         st_ready,
    output logic [63:0]  st_addr,
    output logic [63:0]  st_value,
    output logic [3:0]   st_size,
    output logic         ecall_req,
    output logic [511:0] ecall_args,
    input  logic         ecall_done,
    input  logic [63:0]  ecall_ret,
    output logic [63:0]  retire_count
);

    localparam int PTR_W = $clog2(STQ_DEPTH);
    localparam int CNT_W = $clog2(STQ_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CALL} state_t;

    state_t state, state_next;

    logic [63:0] regs [0:31];

    logic [63:0] stq_addr  [0:STQ_DEPTH-1];
    logic [63:0] stq_value [0:STQ_DEPTH-1];
    logic [3:0]  stq_size  [0:STQ_DEPTH-1];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count, count_next;

    logic        accept;
    logic        push, pop;
    logic        rf_we;
    logic [63:0] rf_wdata;
    logic        ret_we;

    assign wb_stall = (count == CNT_W'(STQ_DEPTH)) | (state != IDLE);
    assign accept   = memwb_ready & ~wb_stall;
    assign push     = accept & memwb_pend_write;
    assign st_valid = (count != '0);
    assign pop      = st_valid & st_ready;

    // Push and pop never conflict on the same entry: a push lands at tail while
    // the pop retires head, so the count simply nets out.
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // rd values of 32 and above are sentinels for "no destination".
    assign rf_we    = accept & memwb_wbactive & ~memwb_ecall &
                      ~memwb_rd[5] & (memwb_rd[4:0] != 5'd0);
    assign rf_wdata = dataselect ? memwb_loadeddata : memwb_aluresult;
    assign ret_we   = (state == CALL) & ecall_done;

    assign ecall_req = (state == CALL);

    assign st_addr  = stq_addr[head];
    assign st_value = stq_value[head];
    assign st_size  = stq_size[head];

    // Register file. The CALL-state x10 write and an accepted write cannot
    // coincide because wb_stall blocks accepts outside IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 2) ? STACK_PTR_INIT : 64'h0;
            end
        end else begin
            if (rf_we) begin
                regs[memwb_rd[4:0]] <= rf_wdata;
            end
            if (ret_we) begin
                regs[10] <= ecall_ret;
            end
        end
    end

    always_comb begin
        rd_data1 = (rd_addr1 == 5'd0) ? 64'h0 : regs[rd_addr1];
        rd_data2 = (rd_addr2 == 5'd0) ? 64'h0 : regs[rd_addr2];
`ifdef WB_BYPASS_EN
        if (rf_we && (rd_addr1 == memwb_rd[4:0])) begin
            rd_data1 = rf_wdata;
        end else if (ret_we && (rd_addr1 == 5'd10)) begin
            rd_data1 = ecall_ret;
        end
        if (rf_we && (rd_addr2 == memwb_rd[4:0])) begin
            rd_data2 = rf_wdata;
        end else if (ret_we && (rd_addr2 == 5'd10)) begin
            rd_data2 = ecall_ret;
        end
`endif
    end

    // Store queue control; entry contents are left as-is on reset since an
    // empty queue never exposes them as valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stq_addr[tail]  <= memwb_addr;
            stq_value[tail] <= memwb_value;
            stq_size[tail]  <= memwb_size;
        end
    end

    // ecall sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && memwb_ecall) state_next = DRAIN;
            // No pushes happen while draining, so count_next reaching zero
            // means the final pop is completing on this edge.
            DRAIN:   if (count_next == '0) state_next = CALL;
            CALL:    if (ecall_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Argument snapshot on entry to CALL.
    always_ff @(posedge clk) begin
        if ((state == DRAIN) && (state_next == CALL)) begin
            for (int i = 0; i < 8; i++) begin
                ecall_args[i*64 +: 64] <= regs[10+i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_count <= 64'h0;
        end else if (accept) begin
            retire_count <= retire_count + 64'd1;
        end
    end

endmodule
